ex_mem_reg: RTL and testbench
=============================

# ex_mem_reg

EX/MEM pipeline register of the five-stage MIPS core; it sits directly upstream of the data memory and drives its address, store data and read/write select. It captures the execute-stage result and control each cycle, supports stall and flush, forwards write-back data into pending store data, and range-checks memory addresses so out-of-range loads and stores never reach the memory array. Faulting accesses are flagged and counted.

## Interface

Parameters:
- DEPTH, 64, number of data-memory words; a valid access is only legal when the address is below DEPTH.
- CNT_W, 8, width of the saturating fault counter.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- stall  in  1  hold every registered output unchanged.
- flush  in  1  load a bubble; has priority over stall.
- exValid  in  1  the EX stage holds a real instruction.
- exResult  in  32  ALU result; for loads and stores this is the word address.
- exReadData2  in  32  rt value from EX, used as store data.
- exRt  in  5  rt register number of the EX instruction.
- exMemRead  in  1  EX instruction is lw.
- exMemWrite  in  1  EX instruction is sw.
- exRegWrite  in  1  EX instruction writes the register file.
- exMemToReg  in  1  write-back source is memory.
- exWriteReg  in  5  destination register number.
- wbRegWrite  in  1  WB stage is writing the register file this cycle.
- wbWriteReg  in  5  WB destination register.
- wbData  in  32  WB write data.
- memValid  out  1  MEM stage holds a real instruction.
- result  out  32  address / ALU result driven to data memory.
- readData2  out  32  store data driven to data memory.
- DataMemRW  out  1  1 = write; asserted only for a valid, in-range sw.
- memRead  out  1  valid, in-range lw.
- regWrite  out  1  gated register-file write enable.
- memToReg  out  1  registered exMemToReg.
- writeReg  out  5  registered exWriteReg.
- memFault  out  1  the held entry is a valid lw/sw whose address is DEPTH or above.
- faultCount  out  CNT_W  saturating count of captured faulting entries.

## Operation

- Capture, when neither flush nor stall is asserted: load every field from the ex* inputs. memValid takes exValid.
- Fault detection: a fault is `exValid & (exMemRead | exMemWrite) & (exResult >= DEPTH)`. The compare is unsigned over all 32 bits.
- Fault gating:
  - memFault is set when the captured entry faults.
  - A faulting entry forces DataMemRW, memRead and regWrite to 0.
  - result still holds the raw address.
- Gated outputs:
  - DataMemRW is `memValid & exMemWrite & ~fault`.
  - memRead is `memValid & exMemRead & ~fault`.
  - regWrite is `memValid & exRegWrite & ~fault`.
- Store-data forwarding at capture: if `wbRegWrite & wbWriteReg == exRt & exRt != 0`, readData2 takes wbData; otherwise it takes exReadData2.
- Forwarding during stall:
  - All fields hold while stalled, except readData2.
  - readData2 takes wbData if `memValid & DataMemRW & wbRegWrite & wbWriteReg == held rt & rt != 0`.
  - Held rt is an internal 5-bit copy of exRt.
- Flush: memValid, DataMemRW, memRead, regWrite, memToReg and memFault go to 0. writeReg, result and readData2 go to 0.
- Flush and stall in the same cycle: flush wins.
- faultCount:
  - Increments by 1 on each edge that captures a faulting entry.
  - It is not incremented by a held (stalled) entry or by a flush.
  - It saturates at 2^CNT_W−1; the count is not cleared except by reset.

## Timing

- Reset (asynchronous assert, synchronous-safe release): every output is 0, including faultCount and the internal rt copy.
- Latency: 1 cycle. Inputs present before edge N appear on the outputs after edge N.
- memFault and the faultCount increment become visible on the same edge as the capture.
- Data memory writes on the falling edge, so result, readData2 and DataMemRW are stable for the half cycle before it.
- A stall of k cycles keeps the same DataMemRW=1 entry for k+1 cycles. Repeated identical writes are allowed.
- Address boundaries: DEPTH−1 (63) is legal; DEPTH (64) and 0xFFFFFFFF fault.
- Reset asserted mid-stall clears the entry immediately. No write reaches memory after reset assertion.
- A faulting sw with a matching WB forward still updates readData2, but DataMemRW stays 0.

## Test plan

- Reset release, then sw with exResult=5, exReadData2=0xA5A5A5A5 -> one edge later: result=5, readData2=0xA5A5A5A5, DataMemRW=1, memFault=0.
- lw with exResult=64 -> memFault=1, memRead=0, regWrite=0, faultCount=1. A following lw to address 63 -> memFault=0, memRead=1, faultCount stays 1.
- sw with exRt=8 while wbRegWrite=1, wbWriteReg=8, wbData=0x1234 -> readData2=0x1234. The same case with exRt=0 -> readData2=exReadData2.
- Hold sw (rt=9) with stall for 3 cycles; during the stall, WB writes r9=0xBEEF -> readData2 becomes 0xBEEF one edge later. All other outputs are unchanged throughout.
- flush=1 and stall=1 together with a valid sw held -> next edge: memValid=0, DataMemRW=0, result=0.
- 300 consecutive faulting loads (CNT_W=8) -> faultCount ends at 255. Assert rst_n=0 mid-sequence -> faultCount=0 and all outputs 0 immediately.

Source files
------------

// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register.
// Captures the execute-stage result and control, supports stall and flush,
// forwards write-back data into pending store data, and blocks data-memory
// accesses whose word address is at or beyond DEPTH. Faulting captures are
// counted in a saturating counter that only reset clears.
module ex_mem_reg #(
    parameter int unsigned DEPTH = 64,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             flush,
    input  logic             exValid,
    input  logic [31:0]      exResult,
    input  logic [31:0]      exReadData2,
    input  logic [4:0]       exRt,
    input  logic             exMemRead,
    input  logic             exMemWrite,
    input  logic             exRegWrite,
    input  logic             exMemToReg,
    input  logic [4:0]       exWriteReg,
    input  logic             wbRegWrite,
    input  logic [4:0]       wbWriteReg,
    input  logic [31:0]      wbData,
    output logic             memValid,
    output logic [31:0]      result,
    output logic [31:0]      readData2,
    output logic             DataMemRW,
    output logic             memRead,
    output logic             regWrite,
    output logic             memToReg,
    output logic [4:0]       writeReg,
    output logic             memFault,
    output logic [CNT_W-1:0] faultCount
);

    localparam logic [31:0] DEPTH_W = 32'(DEPTH);

    logic [4:0] held_rt;
    logic       ex_fault;
    logic       fwd_capture;
    logic       fwd_hold;

    // Decode the out-of-range check and both forwarding conditions.
    always_comb begin
        ex_fault    = exValid & (exMemRead | exMemWrite) & (exResult >= DEPTH_W);
        fwd_capture = wbRegWrite & (wbWriteReg == exRt) & (exRt != 5'd0);
        fwd_hold    = memValid & DataMemRW & wbRegWrite &
                      (wbWriteReg == held_rt) & (held_rt != 5'd0);
    end

    // Pipeline entry: flush beats stall, stall holds all but store data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            memValid  <= 1'b0;
            result    <= '0;
            readData2 <= '0;
            DataMemRW <= 1'b0;
            memRead   <= 1'b0;
            regWrite  <= 1'b0;
            memToReg  <= 1'b0;
            writeReg  <= '0;
            memFault  <= 1'b0;
            held_rt   <= '0;
        end else if (flush) begin
            memValid  <= 1'b0;
            result    <= '0;
            readData2 <= '0;
            DataMemRW <= 1'b0;
            memRead   <= 1'b0;
            regWrite  <= 1'b0;
            memToReg  <= 1'b0;
            writeReg  <= '0;
            memFault  <= 1'b0;
            held_rt   <= '0;
        end else if (stall) begin
            // A held store still picks up a late write-back of its rt.
            if (fwd_hold) begin
                readData2 <= wbData;
            end
        end else begin
            memValid  <= exValid;
            result    <= exResult;
            readData2 <= fwd_capture ? wbData : exReadData2;
            DataMemRW <= exValid & exMemWrite & ~ex_fault;
            memRead   <= exValid & exMemRead & ~ex_fault;
            regWrite  <= exValid & exRegWrite & ~ex_fault;
            memToReg  <= exMemToReg;
            writeReg  <= exWriteReg;
            memFault  <= ex_fault;
            held_rt   <= exRt;
        end
    end

    // Saturating count of faulting captures; stalls and flushes never count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            faultCount <= '0;
        end else if (!flush && !stall && ex_fault && (faultCount != '1)) begin
            faultCount <= faultCount + 1'b1;
        end
    end

endmodule

// File: tb/tb_ex_mem_reg.sv
// Self-checking bench for ex_mem_reg: directed scenarios plus a randomized
// run, all compared against a behavioural model of the pipeline entry.
module tb_ex_mem_reg;

    localparam int unsigned DEPTH = 64;
    localparam int unsigned CNT_W = 8;
    localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        flush;
    logic        exValid;
    logic [31:0] exResult;
    logic [31:0] exReadData2;
    logic [4:0]  exRt;
    logic        exMemRead;
    logic        exMemWrite;
    logic        exRegWrite;
    logic        exMemToReg;
    logic [4:0]  exWriteReg;
    logic        wbRegWrite;
    logic [4:0]  wbWriteReg;
    logic [31:0] wbData;
    logic        memValid;
    logic [31:0] result;
    logic [31:0] readData2;
    logic        DataMemRW;
    logic        memRead;
    logic        regWrite;
    logic        memToReg;
    logic [4:0]  writeReg;
    logic        memFault;
    logic [CNT_W-1:0] faultCount;

    int checks = 0;
    int failures = 0;

    ex_mem_reg #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
        .exValid(exValid), .exResult(exResult), .exReadData2(exReadData2),
        .exRt(exRt), .exMemRead(exMemRead), .exMemWrite(exMemWrite),
        .exRegWrite(exRegWrite), .exMemToReg(exMemToReg), .exWriteReg(exWriteReg),
        .wbRegWrite(wbRegWrite), .wbWriteReg(wbWriteReg), .wbData(wbData),
        .memValid(memValid), .result(result), .readData2(readData2),
        .DataMemRW(DataMemRW), .memRead(memRead), .regWrite(regWrite),
        .memToReg(memToReg), .writeReg(writeReg), .memFault(memFault),
        .faultCount(faultCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: the instruction currently sitting in MEM.
    typedef struct {
        bit        valid;
        bit        is_load;
        bit        is_store;
        bit        writes_reg;
        bit        to_reg;
        bit [31:0] addr;
        bit [31:0] store_data;
        bit [4:0]  rt;
        bit [4:0]  dest;
    } entry_t;

    entry_t m_entry;
    int     m_count;

    function automatic bit out_of_range(entry_t e);
        return e.valid && (e.is_load || e.is_store) && (e.addr >= DEPTH);
    endfunction

    function automatic bit [82:0] model_vec();
        bit bad;
        bad = out_of_range(m_entry);
        return {m_entry.valid, m_entry.addr, m_entry.store_data,
                m_entry.valid && m_entry.is_store && !bad,
                m_entry.valid && m_entry.is_load && !bad,
                m_entry.valid && m_entry.writes_reg && !bad,
                m_entry.to_reg, m_entry.dest, bad, CNT_W'(m_count)};
    endfunction

    function automatic bit [82:0] dut_vec();
        return {memValid, result, readData2, DataMemRW, memRead, regWrite,
                memToReg, writeReg, memFault, faultCount};
    endfunction

    task automatic model_reset();
        m_entry = '{default: 0};
        m_count = 0;
    endtask

    task automatic model_edge();
        entry_t nxt;
        if (!rst_n) begin
            model_reset();
        end else if (flush) begin
            m_entry = '{default: 0};
        end else if (stall) begin
            if (m_entry.valid && m_entry.is_store && !out_of_range(m_entry) &&
                wbRegWrite && wbWriteReg == m_entry.rt && m_entry.rt != 0)
                m_entry.store_data = wbData;
        end else begin
            nxt.valid      = exValid;
            nxt.is_load    = exMemRead;
            nxt.is_store   = exMemWrite;
            nxt.writes_reg = exRegWrite;
            nxt.to_reg     = exMemToReg;
            nxt.addr       = exResult;
            nxt.rt         = exRt;
            nxt.dest       = exWriteReg;
            nxt.store_data = (wbRegWrite && wbWriteReg == exRt && exRt != 0) ? wbData : exReadData2;
            m_entry = nxt;
            if (out_of_range(nxt) && m_count < CNT_MAX) m_count++;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic set_idle();
        stall = 0; flush = 0;
        exValid = 0; exResult = '0; exReadData2 = '0; exRt = '0;
        exMemRead = 0; exMemWrite = 0; exRegWrite = 0; exMemToReg = 0; exWriteReg = '0;
        wbRegWrite = 0; wbWriteReg = '0; wbData = '0;
    endtask

    task automatic set_lw(input logic [31:0] addr, input logic [4:0] dest);
        exValid = 1; exResult = addr; exMemRead = 1; exMemWrite = 0;
        exRegWrite = 1; exMemToReg = 1; exWriteReg = dest; exRt = dest;
        exReadData2 = 32'h0;
    endtask

    task automatic set_sw(input logic [31:0] addr, input logic [31:0] data, input logic [4:0] rt);
        exValid = 1; exResult = addr; exMemRead = 0; exMemWrite = 1;
        exRegWrite = 0; exMemToReg = 0; exWriteReg = 5'd0; exRt = rt;
        exReadData2 = data;
    endtask

    task automatic test_reset();
        set_idle();
        rst_n = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (dut_vec() !== 83'd0) begin
            failures++;
            $display("FAIL reset_outputs got=%h want=0", dut_vec());
        end
        @(negedge clk);
        rst_n = 1;
        step();
        checks++;
        if (dut_vec() !== model_vec()) begin
            failures++;
            $display("FAIL reset_release got=%h want=%h", dut_vec(), model_vec());
        end
    endtask

    task automatic test_store();
        set_idle();
        set_sw(32'd5, 32'hA5A5A5A5, 5'd3);
        step();
        checks++;
        if (result !== 32'd5 || readData2 !== 32'hA5A5A5A5 || DataMemRW !== 1'b1 || memFault !== 1'b0) begin
            failures++;
            $display("FAIL store_basic got res=%h rd2=%h rw=%b flt=%b want res=5 rd2=a5a5a5a5 rw=1 flt=0",
                     result, readData2, DataMemRW, memFault);
        end
        checks++;
        if (dut_vec() !== model_vec()) begin
            failures++;
            $display("FAIL store_model got=%h want=%h", dut_vec(), model_vec());
        end
    endtask

    task automatic test_fault();
        set_idle();
        set_lw(32'd64, 5'd4);
        step();
        checks++;
        if (memFault !== 1'b1 || memRead !== 1'b0 || regWrite !== 1'b0 || faultCount !== 8'd1 || result !== 32'd64) begin
            failures++;
            $display("FAIL lw_addr64 got flt=%b rd=%b rw=%b cnt=%0d res=%0d want 1 0 0 1 64",
                     memFault, memRead, regWrite, faultCount, result);
        end
        set_lw(32'd63, 5'd4);
        step();
        checks++;
        if (memFault !== 1'b0 || memRead !== 1'b1 || regWrite !== 1'b1 || faultCount !== 8'd1) begin
            failures++;
            $display("FAIL lw_addr63 got flt=%b rd=%b rw=%b cnt=%0d want 0 1 1 1",
                     memFault, memRead, regWrite, faultCount);
        end
        set_sw(32'hFFFFFFFF, 32'h11, 5'd2);
        step();
        checks++;
        if (memFault !== 1'b1 || DataMemRW !== 1'b0 || faultCount !== 8'd2) begin
            failures++;
            $display("FAIL sw_addr_max got flt=%b rw=%b cnt=%0d want 1 0 2", memFault, DataMemRW, faultCount);
        end
        // An invalid slot with an out-of-range address is not a fault.
        set_lw(32'd100, 5'd4);
        exValid = 0;
        step();
        checks++;
        if (dut_vec() !== model_vec() || memFault !== 1'b0) begin
            failures++;
            $display("FAIL invalid_no_fault got=%h want=%h", dut_vec(), model_vec());
        end
    endtask

    task automatic test_forward();
        set_idle();
        set_sw(32'd10, 32'h5555, 5'd8);
        wbRegWrite = 1; wbWriteReg = 5'd8; wbData = 32'h1234;
        step();
        checks++;
        if (readData2 !== 32'h1234 || DataMemRW !== 1'b1) begin
            failures++;
            $display("FAIL fwd_rt8 got rd2=%h rw=%b want 00001234 1", readData2, DataMemRW);
        end
        set_sw(32'd10, 32'h5555, 5'd0);
        wbWriteReg = 5'd0;
        step();
        checks++;
        if (readData2 !== 32'h5555) begin
            failures++;
            $display("FAIL fwd_rt0 got rd2=%h want 00005555", readData2);
        end
        set_sw(32'd200, 32'h7777, 5'd6);
        wbWriteReg = 5'd6; wbData = 32'hCAFE;
        step();
        checks++;
        if (readData2 !== 32'hCAFE || DataMemRW !== 1'b0 || memFault !== 1'b1) begin
            failures++;
            $display("FAIL fwd_faulting_sw got rd2=%h rw=%b flt=%b want 0000cafe 0 1", readData2, DataMemRW, memFault);
        end
        checks++;
        if (dut_vec() !== model_vec()) begin
            failures++;
            $display("FAIL fwd_model got=%h want=%h", dut_vec(), model_vec());
        end
    endtask

    task automatic test_stall();
        logic [50:0] held;
        set_idle();
        set_sw(32'd20, 32'h1111, 5'd9);
        step();
        held = {memValid, result, DataMemRW, memRead, regWrite, memToReg, writeReg, memFault, faultCount};
        for (int i = 0; i < 3; i++) begin
            stall = 1;
            set_lw(32'($urandom), 5'($urandom));
            wbRegWrite = (i == 0); wbWriteReg = 5'd9; wbData = 32'hBEEF;
            step();
            checks++;
            if (readData2 !== 32'hBEEF ||
                {memValid, result, DataMemRW, memRead, regWrite, memToReg, writeReg, memFault, faultCount} !== held) begin
                failures++;
                $display("FAIL stall_hold_%0d got rd2=%h rest=%h want 0000beef %h", i, readData2,
                         {memValid, result, DataMemRW, memRead, regWrite, memToReg, writeReg, memFault, faultCount}, held);
            end
        end
    endtask

    task automatic test_flush_stall();
        set_idle();
        set_sw(32'd30, 32'h2222, 5'd7);
        step();
        stall = 1; flush = 1;
        step();
        checks++;
        if (memValid !== 1'b0 || DataMemRW !== 1'b0 || result !== 32'd0 ||
            dut_vec() !== model_vec()) begin
            failures++;
            $display("FAIL flush_over_stall got=%h want=%h", dut_vec(), model_vec());
        end
    endtask

    task automatic test_random();
        int bad = 0;
        int kind;
        for (int i = 0; i < 400; i++) begin
            stall = ($urandom_range(0, 3) == 0);
            flush = ($urandom_range(0, 9) == 0);
            kind = $urandom_range(0, 3);
            exValid     = ($urandom_range(0, 7) != 0);
            exMemRead   = (kind == 1);
            exMemWrite  = (kind == 2);
            exRegWrite  = (kind == 1) || (kind == 3);
            exMemToReg  = (kind == 1);
            exRt        = 5'($urandom_range(0, 3));
            exWriteReg  = 5'($urandom);
            exReadData2 = $urandom;
            case ($urandom_range(0, 3))
                0: exResult = 32'($urandom_range(60, 68));
                1: exResult = 32'hFFFFFFFF;
                2: exResult = 32'($urandom_range(0, 63));
                default: exResult = $urandom;
            endcase
            wbRegWrite = $urandom_range(0, 1);
            wbWriteReg = 5'($urandom_range(0, 3));
            wbData     = $urandom;
            step();
            checks++;
            if (dut_vec() !== model_vec()) begin
                failures++;
                bad++;
                if (bad < 5) $display("FAIL random_cycle_%0d got=%h want=%h", i, dut_vec(), model_vec());
            end
        end
    endtask

    task automatic test_saturate();
        set_idle();
        set_lw(32'd64, 5'd1);
        repeat (300) step();
        checks++;
        if (faultCount !== 8'd255 || dut_vec() !== model_vec()) begin
            failures++;
            $display("FAIL saturate got cnt=%0d vec=%h want cnt=255 vec=%h", faultCount, dut_vec(), model_vec());
        end
        repeat (5) step();
        #2;
        rst_n = 0;
        model_reset();
        #1;
        checks++;
        if (dut_vec() !== 83'd0) begin
            failures++;
            $display("FAIL async_reset got=%h want=0", dut_vec());
        end
        @(negedge clk);
        rst_n = 1;
        step();
        checks++;
        if (faultCount !== 8'd1 || dut_vec() !== model_vec()) begin
            failures++;
            $display("FAIL count_after_reset got cnt=%0d vec=%h want cnt=1 vec=%h", faultCount, dut_vec(), model_vec());
        end
    endtask

    initial begin
        rst_n = 0;
        set_idle();
        model_reset();
        test_reset();
        test_store();
        test_fault();
        test_forward();
        test_stall();
        test_flush_stall();
        test_random();
        test_saturate();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
